l2_bus_request_queue: RTL and testbench
=======================================

Name: l2_bus_request_queue

Overview:
- Downstream neighbour of the L2 cache control model.
- Buffers the bus operations the cache issues on misses, evictions and write hits to Shared lines: memoryRead, memoryWrite and RFO.
- Serialises those operations onto the system bus through a request/grant handshake and samples the snoop response window.
- Retries reads and RFOs that are snooped HITM (another cache writing back), then returns each completed operation with its final snoop result to the cache.

Parameters:
- ADDR_W, 32: bus address width (tag+index+offset).
- DEPTH, 4: request FIFO entries; power of two, minimum 2.
- SNOOP_CYC, 2: length in cycles of the snoop window after grant; range 1..15.
- BACKOFF_CYC, 3: idle cycles between a HITM and re-arbitration; range 1..15.
- MAX_RETRY, 2: maximum HITM retries per operation; range 0..7.

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous reset, active high
- req_valid  in  1  cache presents an operation
- req_ready  out  1  queue can accept
- req_op  in  2  operation code: 01 memoryRead, 10 memoryWrite, 11 RFO, 00 none
- req_addr  in  ADDR_W  line address
- bus_req  out  1  arbitration request
- bus_gnt  in  1  arbitration grant
- bus_op  out  2  operation on the bus; 00 when not in SNOOP or DATA
- bus_addr  out  ADDR_W  address on the bus
- snoop_result  in  2  snoop response: 00 NoHIT, 01 HIT, 10 HITM, 11 treated as NoHIT
- bus_done  in  1  data phase complete
- rsp_valid  out  1  one-cycle completion pulse
- rsp_op  out  2  completed operation
- rsp_addr  out  ADDR_W  completed address
- rsp_snoop  out  2  final sampled snoop result
- rsp_retries  out  3  number of HITM retries taken
- busy  out  1  FSM not in IDLE
- count  out  log2(DEPTH)+1  FIFO occupancy

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: all outputs 0 except req_ready=1. FIFO is empty and the FSM is in IDLE.
- Reset in mid-operation abandons the current operation and all queued entries. No rsp_valid is produced for them.
- FIFO handshake:
  - req_ready = (count != DEPTH), derived from registered count only.
  - An entry is pushed on an edge where req_valid && req_ready && req_op != 00.
  - req_op == 00 is consumed without being enqueued.
  - A push and a pop in the same cycle leave count unchanged. When full, a same-cycle pop does not open ready that cycle.
  - Read and write pointers wrap modulo DEPTH.
- FSM states: IDLE, ARB, SNOOP, BACKOFF, DATA, RESP.
- IDLE:
  - If count != 0: pop the head into the current op/addr registers, clear the retry counter, go to ARB.
- ARB:
  - bus_req=1.
  - If bus_gnt is sampled 1 at the edge, go to SNOOP with the window counter loaded to SNOOP_CYC.
  - bus_gnt is ignored in every other state.
- SNOOP:
  - bus_op and bus_addr are driven; bus_req=0.
  - The counter decrements each cycle. snoop_result is sampled only on the edge where the counter equals 1.
  - If the sample is HITM, op != memoryWrite and retries < MAX_RETRY: increment retries and go to BACKOFF.
  - Otherwise go to DATA.
  - A HITM on memoryWrite, or with retries exhausted, goes to DATA and reports HITM.
- BACKOFF:
  - Bus outputs are 0. Count BACKOFF_CYC cycles, then go to ARB.
- DATA:
  - bus_op and bus_addr are held.
  - Wait for bus_done, then go to RESP. bus_done is ignored outside DATA.
- RESP:
  - rsp_valid=1 for exactly one cycle, with rsp_op, rsp_addr, rsp_snoop and rsp_retries reflecting the completed operation.
  - Return to IDLE. The next pop can occur in the cycle after RESP.
- rsp_* values hold after the pulse until the next RESP.
- Operations complete strictly in FIFO order, one at a time.

Test Plan:
1. Reset, then push read 0x0000_1A40, with bus_gnt and bus_done tied 1 and snoop_result=00. Accept edge E0, ARB after E1, SNOOP E2..E4 → rsp_valid in the cycle after E5 with rsp_op=01, rsp_addr=0x0000_1A40, rsp_snoop=00, rsp_retries=0.
2. Push 5 ops back-to-back with bus_gnt=0 → the first is popped, 4 are queued, req_ready=0 with count=4. Then release bus_gnt → 5 responses come back in push order.
3. RFO 0x0000_2003 with snoop_result=10 on every window, defaults → two BACKOFF passes of 3 cycles each, third window proceeds to DATA, rsp_snoop=10, rsp_retries=2.
4. memoryWrite with snoop_result=10 → no retry, rsp_snoop=10, rsp_retries=0. Read with snoop_result=01 → rsp_snoop=01.
5. Assert rst in the DATA state with 2 entries queued → next cycle count=0, busy=0, bus_op=00, and no rsp_valid for any of them. A req_op=00 push afterwards leaves count=0.

Source files
------------

// File: rtl/l2_bus_request_queue.sv
// L2 bus request queue: buffers cache bus operations and serialises
// them onto the system bus with HITM retry and completion reporting.
module l2_bus_request_queue #(
    parameter int ADDR_W      = 32,
    parameter int DEPTH       = 4,
    parameter int SNOOP_CYC   = 2,
    parameter int BACKOFF_CYC = 3,
    parameter int MAX_RETRY   = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [1:0]                  req_op,
    input  logic [ADDR_W-1:0]           req_addr,
    output logic                        bus_req,
    input  logic                        bus_gnt,
    output logic [1:0]                  bus_op,
    output logic [ADDR_W-1:0]           bus_addr,
    input  logic [1:0]                  snoop_result,
    input  logic                        bus_done,
    output logic                        rsp_valid,
    output logic [1:0]                  rsp_op,
    output logic [ADDR_W-1:0]           rsp_addr,
    output logic [1:0]                  rsp_snoop,
    output logic [2:0]                  rsp_retries,
    output logic                        busy,
    output logic [$clog2(DEPTH):0]      count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] OP_WR = 2'b10;
    localparam logic [1:0] SN_HITM = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        SNOOP,
        BACKOFF,
        DATA,
        RESP
    } state_t;

    state_t state;

    logic [1:0]        op_mem   [DEPTH];
    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    logic [1:0]        cur_op;
    logic [ADDR_W-1:0] cur_addr;
    logic [2:0]        retries;
    logic [3:0]        timer;
    logic [1:0]        snoop_q;

    logic push;
    logic pop;
    logic hitm_retry;

    assign req_ready = (count != CNT_W'(DEPTH));
    assign push = req_valid && req_ready && (req_op != 2'b00);
    assign pop = (state == IDLE) && (count != '0);
    assign busy = (state != IDLE);

    assign hitm_retry = (snoop_result == SN_HITM)
                     && (cur_op != OP_WR)
                     && (retries < 3'(MAX_RETRY));

    // Entry storage; contents need no reset since count guards reads.
    always_ff @(posedge clk) begin
        if (push) begin
            op_mem[wr_ptr]   <= req_op;
            addr_mem[wr_ptr] <= req_addr;
        end
    end

    // Pointer and occupancy tracking; pointers wrap at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    // Bus sequencer: arbitration, snoop window, HITM backoff, data, response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cur_op      <= '0;
            cur_addr    <= '0;
            retries     <= '0;
            timer       <= '0;
            snoop_q     <= '0;
            bus_req     <= 1'b0;
            bus_op      <= '0;
            bus_addr    <= '0;
            rsp_valid   <= 1'b0;
            rsp_op      <= '0;
            rsp_addr    <= '0;
            rsp_snoop   <= '0;
            rsp_retries <= '0;
        end else begin
            rsp_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (count != '0) begin
                        cur_op   <= op_mem[rd_ptr];
                        cur_addr <= addr_mem[rd_ptr];
                        retries  <= '0;
                        bus_req  <= 1'b1;
                        state    <= ARB;
                    end
                end
                ARB: begin
                    if (bus_gnt) begin
                        bus_req  <= 1'b0;
                        bus_op   <= cur_op;
                        bus_addr <= cur_addr;
                        timer    <= 4'(SNOOP_CYC);
                        state    <= SNOOP;
                    end
                end
                SNOOP: begin
                    if (timer == 4'd1) begin
                        // Reserved code 11 is reported as NoHIT.
                        snoop_q <= (snoop_result == 2'b11) ? 2'b00
                                                           : snoop_result;
                        if (hitm_retry) begin
                            retries  <= retries + 1'b1;
                            bus_op   <= '0;
                            bus_addr <= '0;
                            timer    <= 4'(BACKOFF_CYC);
                            state    <= BACKOFF;
                        end else begin
                            state <= DATA;
                        end
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                BACKOFF: begin
                    if (timer == 4'd1) begin
                        bus_req <= 1'b1;
                        state   <= ARB;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                DATA: begin
                    if (bus_done) begin
                        bus_op      <= '0;
                        bus_addr    <= '0;
                        rsp_valid   <= 1'b1;
                        rsp_op      <= cur_op;
                        rsp_addr    <= cur_addr;
                        rsp_snoop   <= snoop_q;
                        rsp_retries <= retries;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_l2_bus_request_queue.sv
// Directed bench for l2_bus_request_queue: latency, ordering,
// HITM retry/backoff, write HITM, and mid-operation reset.
module tb_l2_bus_request_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_addr;
    logic        bus_req;
    logic        bus_gnt;
    logic [1:0]  bus_op;
    logic [31:0] bus_addr;
    logic [1:0]  snoop_result;
    logic        bus_done;
    logic        rsp_valid;
    logic [1:0]  rsp_op;
    logic [31:0] rsp_addr;
    logic [1:0]  rsp_snoop;
    logic [2:0]  rsp_retries;
    logic        busy;
    logic [2:0]  count;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    l2_bus_request_queue dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_addr     (req_addr),
        .bus_req      (bus_req),
        .bus_gnt      (bus_gnt),
        .bus_op       (bus_op),
        .bus_addr     (bus_addr),
        .snoop_result (snoop_result),
        .bus_done     (bus_done),
        .rsp_valid    (rsp_valid),
        .rsp_op       (rsp_op),
        .rsp_addr     (rsp_addr),
        .rsp_snoop    (rsp_snoop),
        .rsp_retries  (rsp_retries),
        .busy         (busy),
        .count        (count)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_tick(input logic [1:0] op, input logic [31:0] a);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = a;
        tick();
        req_valid = 1'b0;
        req_op    = 2'b00;
    endtask

    // Counts ticks until rsp_valid is seen; a timeout is a failed check.
    task automatic wait_rsp(input int max, output int cyc);
        cyc = 0;
        while (cyc < max) begin
            tick();
            cyc++;
            if (rsp_valid) break;
        end
        if (!rsp_valid) chk("rsp_timeout", 0, 1);
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] addr;
    } vec_t;

    vec_t vecs [5];
    int   cyc;
    int   pulses;

    initial begin
        rst = 1'b1;
        req_valid = 1'b0;
        req_op = 2'b00;
        req_addr = '0;
        bus_gnt = 1'b0;
        bus_done = 1'b0;
        snoop_result = 2'b00;
        tick();
        tick();
        rst = 1'b0;

        chk("rst_ready", req_ready, 1);
        chk("rst_count", count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_bus_req", bus_req, 0);
        chk("rst_rsp_valid", rsp_valid, 0);

        // 1: single read, fixed latency
        bus_gnt = 1'b1;
        bus_done = 1'b1;
        push_tick(2'b01, 32'h0000_1A40);
        chk("t1_count_after_push", count, 1);
        tick();
        chk("t1_arb_bus_req", bus_req, 1);
        chk("t1_arb_busy", busy, 1);
        tick();
        chk("t1_snoop_bus_op", bus_op, 2'b01);
        chk("t1_snoop_bus_addr", bus_addr, 32'h0000_1A40);
        chk("t1_snoop_bus_req", bus_req, 0);
        wait_rsp(20, cyc);
        chk("t1_latency", cyc, 3);
        chk("t1_rsp_op", rsp_op, 2'b01);
        chk("t1_rsp_addr", rsp_addr, 32'h0000_1A40);
        chk("t1_rsp_snoop", rsp_snoop, 0);
        chk("t1_rsp_retries", rsp_retries, 0);
        tick();
        chk("t1_pulse_one_cycle", rsp_valid, 0);
        chk("t1_rsp_hold", rsp_addr, 32'h0000_1A40);
        chk("t1_idle", busy, 0);

        // 2: five back-to-back pushes while grant held off
        vecs[0] = '{2'b01, 32'h0000_0100};
        vecs[1] = '{2'b10, 32'h0000_0200};
        vecs[2] = '{2'b11, 32'h0000_0300};
        vecs[3] = '{2'b01, 32'h0000_0400};
        vecs[4] = '{2'b10, 32'h0000_0500};
        bus_gnt = 1'b0;
        for (int i = 0; i < 5; i++) push_tick(vecs[i].op, vecs[i].addr);
        chk("t2_count_full", count, 4);
        chk("t2_ready_low", req_ready, 0);
        chk("t2_arb_wait", bus_req, 1);
        push_tick(2'b11, 32'h0000_0600);
        chk("t2_full_no_push", count, 4);
        bus_gnt = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_rsp(40, cyc);
            chk($sformatf("t2_op%0d", i), rsp_op, vecs[i].op);
            chk($sformatf("t2_addr%0d", i), rsp_addr, vecs[i].addr);
            chk($sformatf("t2_snoop%0d", i), rsp_snoop, 0);
        end
        tick();
        chk("t2_drained", count, 0);

        // 3: RFO HITM every window -> two backoffs then DATA
        snoop_result = 2'b10;
        push_tick(2'b11, 32'h0000_2003);
        tick();
        tick();
        tick();
        tick();
        chk("t3_backoff_bus_op", bus_op, 0);
        chk("t3_backoff_bus_req", bus_req, 0);
        chk("t3_backoff_busy", busy, 1);
        wait_rsp(40, cyc);
        chk("t3_latency", cyc, 13);
        chk("t3_rsp_op", rsp_op, 2'b11);
        chk("t3_rsp_addr", rsp_addr, 32'h0000_2003);
        chk("t3_rsp_snoop", rsp_snoop, 2'b10);
        chk("t3_rsp_retries", rsp_retries, 2);
        tick();

        // 4: write HITM not retried; read HIT reported
        push_tick(2'b10, 32'h0000_3000);
        wait_rsp(20, cyc);
        chk("t4w_latency", cyc, 5);
        chk("t4w_rsp_snoop", rsp_snoop, 2'b10);
        chk("t4w_rsp_retries", rsp_retries, 0);
        tick();
        snoop_result = 2'b01;
        push_tick(2'b01, 32'h0000_3040);
        wait_rsp(20, cyc);
        chk("t4r_rsp_snoop", rsp_snoop, 2'b01);
        chk("t4r_rsp_addr", rsp_addr, 32'h0000_3040);
        chk("t4r_rsp_retries", rsp_retries, 0);
        tick();
        snoop_result = 2'b11;
        push_tick(2'b01, 32'h0000_3080);
        wait_rsp(20, cyc);
        chk("t4x_snoop11_nohit", rsp_snoop, 0);
        tick();
        snoop_result = 2'b00;

        // 5: reset in DATA with two queued entries
        bus_done = 1'b0;
        push_tick(2'b01, 32'h0000_4000);
        push_tick(2'b10, 32'h0000_4040);
        push_tick(2'b11, 32'h0000_4080);
        tick();
        tick();
        chk("t5_in_data_bus_op", bus_op, 2'b01);
        chk("t5_queued", count, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_count", count, 0);
        chk("t5_busy", busy, 0);
        chk("t5_bus_op", bus_op, 0);
        chk("t5_ready", req_ready, 1);
        bus_done = 1'b1;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            if (rsp_valid) pulses++;
            tick();
        end
        chk("t5_no_rsp", pulses, 0);
        push_tick(2'b00, 32'h0000_5000);
        chk("t5_op00_count", count, 0);
        chk("t5_op00_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
